ght_update_queue: RTL and testbench

- Buffers resolved-branch predictor updates (16-bit GHT index plus 1-bit outcome) coming from retire.
- Drains them into the GHT's two write ports (write0/write1) at up to two per cycle.
- Never issues two writes to the same GHT bank in one cycle. Bank = {addr[7:6], addr[0]}.
- Holds off draining while the GHT runs its 32-cycle post-reset init sweep. Sits directly upstream of the GHT write interface.

---
 rtl/ght_update_queue.sv | 133 +++++++++++++
 tb/tb_ght_update_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ght_update_queue.sv
// GHT update queue: buffers retired branch outcomes and drains them into the two GHT write ports
// without bank conflicts. Define GHT_UPD_MERGE_EN to collapse back-to-back writes to the same index.
module ght_update_queue #(
  parameter int DEPTH       = 8,
  parameter int INIT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_vld,
  input  logic [15:0] in0_addr,
  input  logic        in0_val,
  input  logic        in1_vld,
  input  logic [15:0] in1_addr,
  input  logic        in1_val,
  output logic        in_rdy,
  output logic        write0_wen,
  output logic [15:0] write0_addr,
  output logic        write0_val,
  output logic        write1_wen,
  output logic [15:0] write1_addr,
  output logic        write1_val,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(INIT_CYCLES + 1);

  logic [15:0]   addr_mem [DEPTH];
  logic          val_mem  [DEPTH];
  logic [AW-1:0] head, tail, head1;
  logic [CW-1:0] count, free;
  logic [HW-1:0] hold;
  logic [1:0]    npush, ndrop, npop;

  logic          iss0_vld_p0, iss1_vld_p0;
  logic [15:0]   iss0_addr_p0, iss1_addr_p0;
  logic          iss0_val_p0, iss1_val_p0;

  function automatic logic [2:0] bank(input logic [15:0] a);
    return {a[7:6], a[0]};
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign head1  = head + AW'(1);
  assign free   = CW'(DEPTH) - count;
  // Readiness is held low while reset is asserted so retire never sees a false accept.
  assign in_rdy = ~rst & (free >= CW'(2));
  assign npush  = in_rdy ? ({1'b0, in0_vld} + {1'b0, in1_vld}) : 2'd0;
  assign ndrop  = in_rdy ? 2'd0 : ({1'b0, in0_vld} + {1'b0, in1_vld});
  assign busy   = (count != '0) | (hold != '0) | write0_wen | write1_wen;

  // ---- stage p0: pick up to two conflict-free entries from the head ----
  always_comb begin
    iss0_vld_p0  = 1'b0;
    iss0_addr_p0 = '0;
    iss0_val_p0  = 1'b0;
    iss1_vld_p0  = 1'b0;
    iss1_addr_p0 = '0;
    iss1_val_p0  = 1'b0;
    npop         = 2'd0;
    if (hold == '0) begin
`ifdef GHT_UPD_MERGE_EN
      if (count >= CW'(2) && addr_mem[head] == addr_mem[head1]) begin
        iss0_vld_p0  = 1'b1;
        iss0_addr_p0 = addr_mem[head1];
        iss0_val_p0  = val_mem[head1];
        npop         = 2'd2;
      end else
`endif
      if (count >= CW'(1)) begin
        iss0_vld_p0  = 1'b1;
        iss0_addr_p0 = addr_mem[head];
        iss0_val_p0  = val_mem[head];
        npop         = 2'd1;
        if (count >= CW'(2) && bank(addr_mem[head]) != bank(addr_mem[head1])) begin
          iss1_vld_p0  = 1'b1;
          iss1_addr_p0 = addr_mem[head1];
          iss1_val_p0  = val_mem[head1];
          npop         = 2'd2;
        end
      end
    end
  end

  // ---- stage p1: registered pointers, counters and write-port outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      hold        <= HW'(INIT_CYCLES);
      drop_cnt    <= '0;
      write0_wen  <= 1'b0;
      write0_addr <= '0;
      write0_val  <= 1'b0;
      write1_wen  <= 1'b0;
      write1_addr <= '0;
      write1_val  <= 1'b0;
    end else begin
      head        <= head + AW'(npop);
      tail        <= tail + AW'(npush);
      count       <= count + CW'(npush) - CW'(npop);
      if (hold != '0) hold <= hold - HW'(1);
      drop_cnt    <= sat_add8(drop_cnt, ndrop);
      write0_wen  <= iss0_vld_p0;
      write0_addr <= iss0_addr_p0;
      write0_val  <= iss0_val_p0;
      write1_wen  <= iss1_vld_p0;
      write1_addr <= iss1_addr_p0;
      write1_val  <= iss1_val_p0;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by head/count.
  always_ff @(posedge clk) begin
    if (in_rdy) begin
      if (in0_vld) begin
        addr_mem[tail] <= in0_addr;
        val_mem[tail]  <= in0_val;
      end
      if (in1_vld) begin
        addr_mem[tail + AW'(in0_vld)] <= in1_addr;
        val_mem[tail + AW'(in0_vld)]  <= in1_val;
      end
    end
  end
endmodule

// File: tb/tb_ght_update_queue.sv
// Scoreboard bench for ght_update_queue: stimulus queues expected GHT writes with their cycle,
// a negedge monitor pops and compares every write the DUT presents.
module tb_ght_update_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_vld = 1'b0, in1_vld = 1'b0;
  logic [15:0] in0_addr = '0, in1_addr = '0;
  logic        in0_val = 1'b0, in1_val = 1'b0;
  logic        in_rdy, write0_wen, write0_val, write1_wen, write1_val, busy;
  logic [15:0] write0_addr, write1_addr;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          port;
    logic [15:0] addr;
    logic        val;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  ght_update_queue #(.DEPTH(8), .INIT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_addr(in0_addr), .in0_val(in0_val),
    .in1_vld(in1_vld), .in1_addr(in1_addr), .in1_val(in1_val),
    .in_rdy(in_rdy),
    .write0_wen(write0_wen), .write0_addr(write0_addr), .write0_val(write0_val),
    .write1_wen(write1_wen), .write1_addr(write1_addr), .write1_val(write1_val),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_wr(input int port, input logic [15:0] addr, input logic val, input int at);
    exp_t e;
    e.port = port; e.addr = addr; e.val = val; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic mon_write(input int port, input logic [15:0] addr, input logic val);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL write%0d_unexpected: got addr=%h val=%b cyc=%0d, want no write", port, addr, val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.port != port || e.addr !== addr || e.val !== val || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL write%0d: got addr=%h val=%b cyc=%0d, want port=%0d addr=%h val=%b cyc=%0d",
                 port, addr, val, cyc, e.port, e.addr, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (write0_wen === 1'b1) mon_write(0, write0_addr, write0_val);
      else chk("idle0_addr_val", {15'b0, write0_val, write0_addr}, 32'h0);
      if (write1_wen === 1'b1) mon_write(1, write1_addr, write1_val);
      else chk("idle1_addr_val", {15'b0, write1_val, write1_addr}, 32'h0);
    end
  end

  task automatic wait_drain(input string name, input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) tick();
    chk(name, sb.size(), 0);
  endtask

  task automatic drive(input logic v0, input logic [15:0] a0, input logic d0,
                       input logic v1, input logic [15:0] a1, input logic d1);
    in0_vld = v0; in0_addr = a0; in0_val = d0;
    in1_vld = v1; in1_addr = a1; in1_val = d1;
  endtask

  initial begin
    int rel, c1, rel2;
    logic [15:0] a;

    // Reset values
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wen", {write1_wen, write0_wen}, 0);
    chk("rst_drop", drop_cnt, 0);

    // Hold window: one push per cycle from the first non-reset edge
    rst = 1'b0;
    rel = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      a = 16'h1000 + 16'(2 * i);
      drive(1'b1, a, i[0], 1'b0, 16'h0, 1'b0);
      #1;
      chk($sformatf("hold_in_rdy_%0d", i), in_rdy, (i < 7) ? 1 : 0);
      if (i < 7) expect_wr(0, a, i[0], rel + 32 + i);
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_after_fill", drop_cnt, 2);
    while (cyc < rel + 31) tick();
    chk("hold_last_wen", write0_wen, 0);
    chk("hold_last_busy", busy, 1);
    wait_drain("drain_hold", 60);
    tick();
    chk("idle_busy", busy, 0);

    // Different banks pair on both ports in one cycle (pointers wrap here)
    drive(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0040, 1'b0);
    expect_wr(0, 16'h1234, 1'b1, cyc + 2);
    expect_wr(1, 16'h0040, 1'b0, cyc + 2);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    wait_drain("drain_pair", 10);

    // Same bank serialises on port 0
    drive(1'b1, 16'h0001, 1'b1, 1'b1, 16'h0101, 1'b0);
    expect_wr(0, 16'h0001, 1'b1, cyc + 2);
    expect_wr(0, 16'h0101, 1'b0, cyc + 3);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    wait_drain("drain_serial", 10);

    // Two pushes per cycle against one pop per cycle until full; last pair dropped
    c1 = cyc + 1;
    for (int j = 0; j < 7; j++) begin
      if (j < 6)
        drive(1'b1, 16'h2000 + 16'(4 * j), j[0], 1'b1, 16'h2002 + 16'(4 * j), ~j[0]);
      else
        drive(1'b1, 16'h3000, 1'b1, 1'b1, 16'h3002, 1'b1);
      #1;
      chk($sformatf("fill_in_rdy_%0d", j), in_rdy, (j < 6) ? 1 : 0);
      if (j < 6) begin
        expect_wr(0, 16'h2000 + 16'(4 * j), j[0], c1 + 1 + 2 * j);
        expect_wr(0, 16'h2002 + 16'(4 * j), ~j[0], c1 + 2 + 2 * j);
      end
      tick();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("drop_after_full", drop_cnt, 4);
    tick();
    chk("pre_rst_wen", write0_wen, 1);
    chk("pre_rst_addr", write0_addr, 32'h200C);

    // Reset mid-drain with five entries queued
    rst = 1'b1;
    while (sb.size() != 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    tick();
    chk("mid_rst_wen", {write1_wen, write0_wen}, 0);
    chk("mid_rst_addr", {write1_addr, write0_addr}, 0);
    chk("mid_rst_val", {write1_val, write0_val}, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_in_rdy", in_rdy, 0);
    rst = 1'b0;
    drive(1'b1, 16'h4000, 1'b1, 1'b0, 16'h0, 1'b0);
    #1;
    chk("post_rst_in_rdy", in_rdy, 1);
    rel2 = cyc + 1;
    expect_wr(0, 16'h4000, 1'b1, rel2 + 32);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    while (cyc < rel2 + 31) tick();
    chk("rehold_last_wen", write0_wen, 0);
    wait_drain("drain_rehold", 10);

    // Identical addresses back to back
    drive(1'b1, 16'h00C0, 1'b1, 1'b1, 16'h00C0, 1'b0);
`ifdef GHT_UPD_MERGE_EN
    expect_wr(0, 16'h00C0, 1'b0, cyc + 2);
`else
    expect_wr(0, 16'h00C0, 1'b1, cyc + 2);
    expect_wr(0, 16'h00C0, 1'b0, cyc + 3);
`endif
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    wait_drain("drain_same_addr", 10);
    repeat (3) tick();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
